// File: rtl/mram_serial_ctrl_pkg.sv
// mram_ctrl_pkg: shared types, strobe levels and configuration helpers for
// the serial MRAM controller.
package mram_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_SEND   = 2'd3
    } state_t;

    // MRAM strobes are active low.
    localparam logic STROBE_ON  = 1'b0;
    localparam logic STROBE_OFF = 1'b1;

    // Number of byte lanes in one MRAM word.
    function automatic int lane_count(input int data_w, input int lane_w);
        return data_w / lane_w;
    endfunction

    // Legal parameter combination check used at elaboration.
    function automatic bit cfg_ok(input int data_w, input int addr_w,
                                  input int lane_w, input int wait_cyc);
        bit ok;
        ok = 1'b1;
        if ((lane_w <= 0) || ((data_w % lane_w) != 0)) ok = 1'b0;
        else if (data_w > addr_w)                        ok = 1'b0;
        else if ((data_w / lane_w) > 4)                  ok = 1'b0;
        else if ((wait_cyc < 0) || (wait_cyc > 15))      ok = 1'b0;
        else                                             ok = 1'b1;
        return ok;
    endfunction

    // Population count of up to four lane enables.
    function automatic logic [2:0] popcount4(input logic [3:0] v);
        return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
    endfunction

endpackage

// File: rtl/mram_serial_ctrl_if.sv
// Host-side command / serial link of the MRAM controller.
// Optional macro MRAM_BURST_EN adds the cmd_burst request bit.
interface mram_serial_ctrl_if #(
    parameter int NLANES = 2
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_we;
    logic [NLANES-1:0] cmd_be;
`ifdef MRAM_BURST_EN
    logic              cmd_burst;
`endif
    logic              addr_sdi;
    logic              data_sdi;
    logic              rd_sdo;
    logic              rd_sdo_valid;
    logic              done;

    modport master (
        output cmd_valid, cmd_we, cmd_be,
`ifdef MRAM_BURST_EN
        output cmd_burst,
`endif
        output addr_sdi, data_sdi,
        input  cmd_ready, rd_sdo, rd_sdo_valid, done
    );

    modport slave (
        input  cmd_valid, cmd_we, cmd_be,
`ifdef MRAM_BURST_EN
        input  cmd_burst,
`endif
        input  addr_sdi, data_sdi,
        output cmd_ready, rd_sdo, rd_sdo_valid, done
    );
endinterface

// File: rtl/mram_serial_ctrl_shift_reg.sv
// mram_shift_reg: parallel-load register that shifts MSB first; used for
// address deserialising, write-data deserialising and read-data serialising.
module mram_shift_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         shift_en,
    input  logic         sin,
    output logic [W-1:0] q
);
    logic [W-1:0] q_r;
    logic [W-1:0] shifted_s;

    if (W > 1) begin : g_wide
        assign shifted_s = {q_r[W-2:0], sin};
    end else begin : g_single
        assign shifted_s = sin;
    end

    // Holding register: load has priority over shift.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q_r <= '0;
        end else if (load) begin
            q_r <= load_val;
        end else if (shift_en) begin
            q_r <= shifted_s;
        end else begin
            q_r <= q_r;
        end
    end

    assign q = q_r;
endmodule

// File: rtl/mram_serial_ctrl.sv
// mram_serial_ctrl: deserialises an address (and write data), runs one
// async-SRAM-style MRAM cycle, and reserialises the enabled read lanes.
// Optional macro MRAM_BURST_EN: cmd_burst chains to previous address + 1.
module mram_serial_ctrl
    import mram_ctrl_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 20,
    parameter int LANE_W   = 8,
    parameter int WAIT_CYC = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    mram_serial_ctrl_if.slave        host,
    output logic [ADDR_W-1:0]        mram_addr,
    output logic [DATA_W-1:0]        mram_dq_out,
    output logic                     mram_dq_oe,
    input  logic [DATA_W-1:0]        mram_dq_in,
    output logic                     ce_n,
    output logic                     we_n,
    output logic                     oe_n,
    output logic [DATA_W/LANE_W-1:0] lane_n
);
    localparam int NLANES = lane_count(DATA_W, LANE_W);
    localparam int MAXW   = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
    localparam int CNT_W  = $clog2(MAXW + 1);

    if (!cfg_ok(DATA_W, ADDR_W, LANE_W, WAIT_CYC)) begin : g_cfg_err
        $error("mram_serial_ctrl: illegal DATA_W/ADDR_W/LANE_W/WAIT_CYC combination");
    end

    state_t              state_r, state_next;
    logic [CNT_W-1:0]    cnt_r, cnt_next;
    logic [3:0]          wait_r, wait_next;
    logic                we_r, we_next;
    logic [NLANES-1:0]   be_r, be_next;
    logic                burst_r, burst_next;
    logic                burst_eff_s;
    logic                accept_s;
    logic                done_next;
    logic                addr_load_s, addr_shift_s, data_shift_s;
    logic                rd_load_s, rd_shift_s;
    logic [CNT_W-1:0]    shift_last_s, send_last_s;
    logic [3:0]          be4_s;
    logic [2:0]          pc_s;
    logic [DATA_W-1:0]   packed_s;
    logic [ADDR_W-1:0]   addr_q_s;
    logic [DATA_W-1:0]   rd_q_s;
    logic                rd_sdo_unused_s;

    logic                cmd_ready_r, done_r, rd_valid_r;
    logic                ce_n_r, we_n_r, oe_n_r, dq_oe_r;
    logic [NLANES-1:0]   lane_n_r;
    logic                access_next_s;

    assign accept_s = host.cmd_valid & cmd_ready_r;

`ifdef MRAM_BURST_EN
    logic last_ok_r;

    // Remembers that a read/write finished since reset, so the stored address is valid.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_ok_r <= 1'b0;
        end else if (done_next && (state_r != ST_IDLE)) begin
            last_ok_r <= 1'b1;
        end else begin
            last_ok_r <= last_ok_r;
        end
    end

    assign burst_eff_s = host.cmd_burst & last_ok_r;
`else
    assign burst_eff_s = 1'b0;
`endif

    // Lane bookkeeping: popcount, SEND length and left-aligned packing of enabled read lanes.
    always_comb begin
        be4_s = 4'b0000;
        be4_s[NLANES-1:0] = be_r;
        pc_s = popcount4(be4_s);
        send_last_s = CNT_W'(int'(pc_s) * LANE_W - 1);
        shift_last_s = burst_r ? CNT_W'(DATA_W - 1) : CNT_W'(ADDR_W - 1);
        packed_s = '0;
        for (int i = NLANES - 1; i >= 0; i--) begin
            if (be_r[i]) begin
                packed_s = (packed_s << LANE_W) | DATA_W'(mram_dq_in[i*LANE_W +: LANE_W]);
            end else begin
                packed_s = packed_s;
            end
        end
        packed_s = packed_s << ((NLANES - int'(pc_s)) * LANE_W);
    end

    // Next-state logic and shift-register controls.
    always_comb begin
        state_next   = state_r;
        cnt_next     = cnt_r;
        wait_next    = wait_r;
        we_next      = we_r;
        be_next      = be_r;
        burst_next   = burst_r;
        done_next    = 1'b0;
        addr_load_s  = 1'b0;
        addr_shift_s = 1'b0;
        data_shift_s = 1'b0;
        rd_load_s    = 1'b0;
        rd_shift_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    we_next    = host.cmd_we;
                    be_next    = host.cmd_be;
                    burst_next = burst_eff_s;
                    cnt_next   = '0;
                    wait_next  = 4'd0;
                    if (host.cmd_be == {NLANES{1'b0}}) begin
                        done_next = 1'b1;
                    end else if (burst_eff_s && !host.cmd_we) begin
                        addr_load_s = 1'b1;
                        state_next  = ST_ACCESS;
                    end else begin
                        addr_load_s = burst_eff_s;
                        state_next  = ST_SHIFT;
                    end
                end else begin
                    state_next = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                addr_shift_s = ~burst_r;
                data_shift_s = we_r && (cnt_r < CNT_W'(DATA_W));
                if (cnt_r == shift_last_s) begin
                    cnt_next   = '0;
                    wait_next  = 4'd0;
                    state_next = ST_ACCESS;
                end else begin
                    cnt_next = cnt_r + CNT_W'(1);
                end
            end
            ST_ACCESS: begin
                if (wait_r == 4'(WAIT_CYC)) begin
                    cnt_next = '0;
                    if (we_r) begin
                        done_next  = 1'b1;
                        state_next = ST_IDLE;
                    end else begin
                        rd_load_s  = 1'b1;
                        state_next = ST_SEND;
                    end
                end else begin
                    wait_next = wait_r + 4'd1;
                end
            end
            ST_SEND: begin
                rd_shift_s = 1'b1;
                if (cnt_r == send_last_s) begin
                    done_next  = 1'b1;
                    state_next = ST_IDLE;
                end else begin
                    cnt_next = cnt_r + CNT_W'(1);
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign access_next_s = (state_next == ST_ACCESS);

    // State, counters and latched command fields.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            cnt_r   <= '0;
            wait_r  <= 4'd0;
            we_r    <= 1'b0;
            be_r    <= '0;
            burst_r <= 1'b0;
        end else begin
            state_r <= state_next;
            cnt_r   <= cnt_next;
            wait_r  <= wait_next;
            we_r    <= we_next;
            be_r    <= be_next;
            burst_r <= burst_next;
        end
    end

    // Registered strobes and handshake outputs, decoded from the next state so they align with it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cmd_ready_r <= 1'b1;
            done_r      <= 1'b0;
            rd_valid_r  <= 1'b0;
            ce_n_r      <= STROBE_OFF;
            we_n_r      <= STROBE_OFF;
            oe_n_r      <= STROBE_OFF;
            dq_oe_r     <= 1'b0;
            lane_n_r    <= {NLANES{STROBE_OFF}};
        end else begin
            cmd_ready_r <= (state_next == ST_IDLE);
            done_r      <= done_next;
            rd_valid_r  <= (state_next == ST_SEND);
            ce_n_r      <= access_next_s ? STROBE_ON : STROBE_OFF;
            we_n_r      <= (access_next_s && we_next) ? STROBE_ON : STROBE_OFF;
            oe_n_r      <= (access_next_s && !we_next) ? STROBE_ON : STROBE_OFF;
            dq_oe_r     <= access_next_s && we_next;
            lane_n_r    <= access_next_s ? ~be_next : {NLANES{STROBE_OFF}};
        end
    end

    mram_shift_reg #(.W(ADDR_W)) u_addr_sr (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (addr_load_s),
        .load_val (addr_q_s + ADDR_W'(1)),
        .shift_en (addr_shift_s),
        .sin      (host.addr_sdi),
        .q        (addr_q_s)
    );

    mram_shift_reg #(.W(DATA_W)) u_data_sr (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (1'b0),
        .load_val ({DATA_W{1'b0}}),
        .shift_en (data_shift_s),
        .sin      (host.data_sdi),
        .q        (mram_dq_out)
    );

    mram_shift_reg #(.W(DATA_W)) u_rd_sr (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (rd_load_s),
        .load_val (packed_s),
        .shift_en (rd_shift_s),
        .sin      (1'b0),
        .q        (rd_q_s)
    );

    // Only the MSB of the read serialiser leaves the block.
    assign rd_sdo_unused_s = ^rd_q_s;

    assign mram_addr         = addr_q_s;
    assign mram_dq_oe        = dq_oe_r;
    assign ce_n              = ce_n_r;
    assign we_n              = we_n_r;
    assign oe_n              = oe_n_r;
    assign lane_n            = lane_n_r;
    assign host.cmd_ready    = cmd_ready_r;
    assign host.done         = done_r;
    assign host.rd_sdo_valid = rd_valid_r;
    assign host.rd_sdo       = rd_q_s[DATA_W-1];
endmodule

// File: tb/tb_mram_serial_ctrl.sv
// Directed testbench for mram_serial_ctrl (default parameters).
module tb_mram_serial_ctrl;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [19:0] mram_addr;
    logic [15:0] mram_dq_out;
    logic        mram_dq_oe;
    logic [15:0] mram_dq_in;
    logic        ce_n, we_n, oe_n;
    logic [1:0]  lane_n;

    int errors = 0;
    int checks = 0;

    // observations collected by run_cmd
    int          obs_done, obs_ce, obs_we, obs_oe, obs_drv, obs_rd_cnt;
    logic [1:0]  obs_lane;
    logic [19:0] obs_addr;
    logic [15:0] obs_dq, obs_rd;
    logic        obs_ready_acc, obs_ready_bad, obs_strobe_bad, obs_unstable;

    mram_serial_ctrl_if #(.NLANES(2)) host ();

    mram_serial_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .host        (host),
        .mram_addr   (mram_addr),
        .mram_dq_out (mram_dq_out),
        .mram_dq_oe  (mram_dq_oe),
        .mram_dq_in  (mram_dq_in),
        .ce_n        (ce_n),
        .we_n        (we_n),
        .oe_n        (oe_n),
        .lane_n      (lane_n)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one command and monitor until done (bounded); no checking here.
    task automatic run_cmd(input logic we, input logic [1:0] be, input logic [19:0] a,
                           input logic [15:0] d, input logic burst, input logic [15:0] rdat);
        obs_done = -1; obs_ce = 0; obs_we = 0; obs_oe = 0; obs_drv = 0; obs_rd_cnt = 0;
        obs_lane = 2'b11; obs_addr = 20'h0; obs_dq = 16'h0; obs_rd = 16'h0;
        obs_ready_bad = 1'b0; obs_strobe_bad = 1'b0; obs_unstable = 1'b0;
        obs_ready_acc = host.cmd_ready;
        mram_dq_in = ~rdat;
        host.cmd_valid = 1'b1;
        host.cmd_we = we;
        host.cmd_be = be;
`ifdef MRAM_BURST_EN
        host.cmd_burst = burst;
`else
        if (burst) $display("note: burst request ignored in this build");
`endif
        tick();
        host.cmd_valid = 1'b0;
        for (int c = 0; c < 80; c++) begin
            if (ce_n === 1'b0) begin
                if (obs_ce == 0) begin
                    obs_addr = mram_addr;
                    obs_dq = mram_dq_out;
                end else if (mram_addr !== obs_addr || mram_dq_out !== obs_dq) begin
                    obs_unstable = 1'b1;
                end
                obs_ce++;
                obs_lane = lane_n;
            end else if (we_n !== 1'b1 || oe_n !== 1'b1 || mram_dq_oe !== 1'b0 || lane_n !== 2'b11) begin
                obs_strobe_bad = 1'b1;
            end
            if (we_n === 1'b0) obs_we++;
            if (oe_n === 1'b0) obs_oe++;
            if (mram_dq_oe === 1'b1) obs_drv++;
            if (host.rd_sdo_valid === 1'b1) begin
                obs_rd = {obs_rd[14:0], host.rd_sdo};
                obs_rd_cnt++;
            end
            if (host.done === 1'b1) begin
                obs_done = c + 1;
                break;
            end
            if (host.cmd_ready !== 1'b0) obs_ready_bad = 1'b1;
            host.addr_sdi = (c < 20) ? a[19 - c] : 1'b0;
            host.data_sdi = (c < 16) ? d[15 - c] : 1'b1;
            mram_dq_in = (obs_oe >= 2) ? rdat : ~rdat;
            tick();
        end
    endtask

    // Accept a write and feed ncyc serial bits, leaving the command unfinished.
    task automatic start_write(input int ncyc);
        host.cmd_valid = 1'b1; host.cmd_we = 1'b1; host.cmd_be = 2'b11;
`ifdef MRAM_BURST_EN
        host.cmd_burst = 1'b0;
`endif
        tick();
        host.cmd_valid = 1'b0;
        for (int c = 0; c < ncyc; c++) begin
            host.addr_sdi = c[0];
            host.data_sdi = ~c[0];
            tick();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick(); tick();
        checks++; if (host.cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", host.cmd_ready); end
        checks++; if ({ce_n, we_n, oe_n} !== 3'b111) begin errors++; $display("FAIL reset_strobes: got %b want 111", {ce_n, we_n, oe_n}); end
        checks++; if (lane_n !== 2'b11) begin errors++; $display("FAIL reset_lane_n: got %b want 11", lane_n); end
        checks++; if ({mram_dq_oe, host.rd_sdo, host.rd_sdo_valid, host.done} !== 4'b0000) begin errors++; $display("FAIL reset_flags: got %b want 0000", {mram_dq_oe, host.rd_sdo, host.rd_sdo_valid, host.done}); end
        checks++; if (mram_addr !== 20'h0 || mram_dq_out !== 16'h0) begin errors++; $display("FAIL reset_regs: got %h/%h want 0/0", mram_addr, mram_dq_out); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_full_write();
        run_cmd(1'b1, 2'b11, 20'hA5A5A, 16'h1234, 1'b0, 16'h0000);
        checks++; if (obs_ready_acc !== 1'b1) begin errors++; $display("FAIL wr_ready: got %b want 1", obs_ready_acc); end
        checks++; if (obs_done != 23) begin errors++; $display("FAIL wr_latency: got %0d want 23", obs_done); end
        checks++; if (obs_ce != 2 || obs_we != 2 || obs_oe != 0 || obs_drv != 2) begin errors++; $display("FAIL wr_strobe_cycles: got ce=%0d we=%0d oe=%0d drv=%0d want 2 2 0 2", obs_ce, obs_we, obs_oe, obs_drv); end
        checks++; if (obs_lane !== 2'b00) begin errors++; $display("FAIL wr_lane_n: got %b want 00", obs_lane); end
        checks++; if (obs_addr !== 20'hA5A5A) begin errors++; $display("FAIL wr_addr: got %h want a5a5a", obs_addr); end
        checks++; if (obs_dq !== 16'h1234) begin errors++; $display("FAIL wr_dq: got %h want 1234", obs_dq); end
        checks++; if (obs_unstable || obs_strobe_bad || obs_ready_bad || obs_rd_cnt != 0) begin errors++; $display("FAIL wr_protocol: got unstable=%b strobe=%b ready=%b rd=%0d want 0 0 0 0", obs_unstable, obs_strobe_bad, obs_ready_bad, obs_rd_cnt); end
    endtask

    task automatic test_lane_read();
        run_cmd(1'b0, 2'b10, 20'h12345, 16'hFFFF, 1'b0, 16'hBEEF);
        checks++; if (obs_oe != 2 || obs_we != 0 || obs_drv != 0) begin errors++; $display("FAIL lrd_strobe_cycles: got oe=%0d we=%0d drv=%0d want 2 0 0", obs_oe, obs_we, obs_drv); end
        checks++; if (obs_lane !== 2'b01) begin errors++; $display("FAIL lrd_lane_n: got %b want 01", obs_lane); end
        checks++; if (obs_addr !== 20'h12345) begin errors++; $display("FAIL lrd_addr: got %h want 12345", obs_addr); end
        checks++; if (obs_rd_cnt != 8 || obs_rd !== 16'h00BE) begin errors++; $display("FAIL lrd_data: got %0d bits %h want 8 bits 00be", obs_rd_cnt, obs_rd); end
        checks++; if (obs_done != 31) begin errors++; $display("FAIL lrd_latency: got %0d want 31", obs_done); end
        checks++; if (obs_strobe_bad || obs_ready_bad) begin errors++; $display("FAIL lrd_protocol: got strobe=%b ready=%b want 0 0", obs_strobe_bad, obs_ready_bad); end
    endtask

    task automatic test_full_read();
        run_cmd(1'b0, 2'b11, 20'h00F0F, 16'h0000, 1'b0, 16'h8001);
        checks++; if (obs_ready_acc !== 1'b1) begin errors++; $display("FAIL frd_ready: got %b want 1", obs_ready_acc); end
        checks++; if (obs_rd_cnt != 16 || obs_rd !== 16'h8001) begin errors++; $display("FAIL frd_data: got %0d bits %h want 16 bits 8001", obs_rd_cnt, obs_rd); end
        checks++; if (obs_done != 39) begin errors++; $display("FAIL frd_latency: got %0d want 39", obs_done); end
        checks++; if (obs_lane !== 2'b00 || obs_oe != 2) begin errors++; $display("FAIL frd_access: got lane=%b oe=%0d want 00 2", obs_lane, obs_oe); end
    endtask

    task automatic test_back_to_back();
        run_cmd(1'b1, 2'b00, 20'hFFFFF, 16'hFFFF, 1'b0, 16'h0000);
        checks++; if (obs_done != 1) begin errors++; $display("FAIL nop_latency: got %0d want 1", obs_done); end
        checks++; if (obs_ce != 0 || obs_strobe_bad) begin errors++; $display("FAIL nop_strobes: got ce=%0d bad=%b want 0 0", obs_ce, obs_strobe_bad); end
        run_cmd(1'b1, 2'b01, 20'h0F00F, 16'hC3A5, 1'b0, 16'h0000);
        checks++; if (obs_ready_acc !== 1'b1) begin errors++; $display("FAIL b2b_ready: got %b want 1", obs_ready_acc); end
        checks++; if (obs_done != 23) begin errors++; $display("FAIL b2b_latency: got %0d want 23", obs_done); end
        checks++; if (obs_lane !== 2'b10 || obs_addr !== 20'h0F00F || obs_dq !== 16'hC3A5) begin errors++; $display("FAIL b2b_access: got %b %h %h want 10 0f00f c3a5", obs_lane, obs_addr, obs_dq); end
    endtask

    task automatic test_reset_mid_op();
        int done_seen;
        start_write(5);
        rst_n = 1'b0;
        tick();
        checks++; if ({ce_n, we_n, mram_dq_oe, host.cmd_ready, host.done} !== 5'b11010) begin errors++; $display("FAIL rst_shift: got %b want 11010", {ce_n, we_n, mram_dq_oe, host.cmd_ready, host.done}); end
        rst_n = 1'b1;
        done_seen = 0;
        for (int c = 0; c < 30; c++) begin
            tick();
            if (host.done === 1'b1) done_seen++;
        end
        checks++; if (done_seen != 0) begin errors++; $display("FAIL rst_no_done: got %0d want 0", done_seen); end
        start_write(20);
        checks++; if (ce_n !== 1'b0) begin errors++; $display("FAIL rst_pre_access: got %b want 0", ce_n); end
        rst_n = 1'b0;
        tick();
        checks++; if ({ce_n, we_n, oe_n, lane_n, mram_dq_oe, host.done} !== 7'b1111100) begin errors++; $display("FAIL rst_access: got %b want 1111100", {ce_n, we_n, oe_n, lane_n, mram_dq_oe, host.done}); end
        checks++; if (mram_addr !== 20'h0) begin errors++; $display("FAIL rst_access_addr: got %h want 0", mram_addr); end
        rst_n = 1'b1;
        tick();
    endtask

`ifdef MRAM_BURST_EN
    task automatic test_burst();
        run_cmd(1'b1, 2'b11, 20'hFFFFF, 16'h1111, 1'b0, 16'h0000);
        checks++; if (obs_addr !== 20'hFFFFF) begin errors++; $display("FAIL bst_first_addr: got %h want fffff", obs_addr); end
        run_cmd(1'b1, 2'b11, 20'h5A5A5, 16'h2222, 1'b1, 16'h0000);
        checks++; if (obs_addr !== 20'h00000 || obs_dq !== 16'h2222) begin errors++; $display("FAIL bst_wrap: got %h %h want 00000 2222", obs_addr, obs_dq); end
        checks++; if (obs_done != 19) begin errors++; $display("FAIL bst_wr_latency: got %0d want 19", obs_done); end
        run_cmd(1'b0, 2'b11, 20'h5A5A5, 16'h0000, 1'b1, 16'h4321);
        checks++; if (obs_addr !== 20'h00001 || obs_rd !== 16'h4321 || obs_done != 19) begin errors++; $display("FAIL bst_read: got %h %h %0d want 00001 4321 19", obs_addr, obs_rd, obs_done); end
    endtask
`endif

    initial begin
        rst_n = 1'b0;
        mram_dq_in = 16'h0;
        host.cmd_valid = 1'b0; host.cmd_we = 1'b0; host.cmd_be = 2'b00;
        host.addr_sdi = 1'b0; host.data_sdi = 1'b0;
`ifdef MRAM_BURST_EN
        host.cmd_burst = 1'b0;
`endif
        test_reset();
        test_full_write();
        test_lane_read();
        test_full_read();
        test_back_to_back();
        test_reset_mid_op();
`ifdef MRAM_BURST_EN
        test_burst();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
